// File: rtl/icache_refill_ctrl.sv
// Refill sequencer for the ping-pong instruction buffer: demand-fills the active
// bank, prefetches the next sequential line into the backup bank, swaps on Switch.
module icache_refill_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              Switch,
    input  logic              Miss,
    input  logic [ADDR_W-1:0] Miss_Addr,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic              Fill_We,
    output logic              Fill_Bank,
    output logic [2:0]        Fill_Idx,
    output logic [DATA_W-1:0] Fill_Data,
    output logic              Bnd_We,
    output logic              Bnd_Bank,
    output logic [ADDR_W-1:0] Bnd_Lb,
    output logic              Active_Bank,
    output logic              Stall,
    output logic              Ready
);

    typedef enum logic [1:0] {START, FILL_ACT, FILL_BKP, READY} state_e;

    localparam logic [ADDR_W-1:0] LINE  = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] LINE2 = ADDR_W'(16);

    state_e            state_q, state_d;
    logic              act_q, act_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] abase_q, abase_d;
    logic [2:0]        idx_q, idx_d;
    logic              req_q, stall_q, ready_q;
    logic [ADDR_W-1:0] addr_q;

    logic tgt, wr, last;

    // A miss in the same cycle as an ack kills the write: the line is abandoned.
    always_comb begin
        tgt  = (state_q == FILL_BKP) ? ~act_q : act_q;
        wr   = req_q & Mem_Ack & ~Miss;
        last = wr & (idx_q == 3'd7);
    end

    assign Mem_Req     = req_q;
    assign Mem_Addr    = addr_q;
    assign Fill_We     = wr;
    assign Fill_Bank   = tgt;
    assign Fill_Idx    = idx_q;
    assign Fill_Data   = req_q ? Mem_Data : '0;
    assign Bnd_We      = last;
    assign Bnd_Bank    = tgt;
    assign Bnd_Lb      = base_q;
    assign Active_Bank = act_q;
    assign Stall       = stall_q;
    assign Ready       = ready_q;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        base_d  = base_q;
        abase_d = abase_q;
        idx_d   = idx_q;
        if (wr) idx_d = idx_q + 3'd1;
        case (state_q)
            START: begin
                state_d = FILL_ACT;
                act_d   = 1'b0;
                base_d  = '0;
                idx_d   = '0;
            end
            FILL_ACT: begin
                if (last) begin
                    abase_d = base_q;
                    base_d  = base_q + LINE;
                    state_d = FILL_BKP;
                end
            end
            FILL_BKP: begin
                if (last) begin
                    // Line done and fetch crosses into it on the same edge:
                    // behave as a Switch out of READY.
                    if (Switch) begin
                        act_d   = ~act_q;
                        abase_d = base_q;
                        base_d  = base_q + LINE;
                    end else begin
                        state_d = READY;
                    end
                end else if (Switch) begin
                    // Finish the partly written line as the new active bank.
                    act_d   = ~act_q;
                    abase_d = base_q;
                    state_d = FILL_ACT;
                end
            end
            READY: begin
                if (Switch) begin
                    act_d   = ~act_q;
                    abase_d = abase_q + LINE;
                    base_d  = abase_q + LINE2;
                    idx_d   = '0;
                    state_d = FILL_BKP;
                end
            end
            default: state_d = START;
        endcase
        if (Miss && state_q != START) begin
            act_d   = act_q;
            abase_d = abase_q;
            base_d  = {Miss_Addr[ADDR_W-1:3], 3'b000};
            idx_d   = '0;
            state_d = FILL_ACT;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= START;
            act_q   <= 1'b0;
            base_q  <= '0;
            abase_q <= '0;
            idx_q   <= '0;
            req_q   <= 1'b0;
            stall_q <= 1'b1;
            ready_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            base_q  <= base_d;
            abase_q <= abase_d;
            idx_q   <= idx_d;
            req_q   <= (state_d == FILL_ACT) || (state_d == FILL_BKP);
            stall_q <= (state_d == FILL_ACT);
            ready_q <= (state_d == READY);
            addr_q  <= base_d + {{(ADDR_W-3){1'b0}}, idx_d};
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: line-level reference model predicts
// per-cycle status, word writes and bound updates; a monitor pops and compares.
module tb_icache_refill_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Switch = 1'b0, Miss = 1'b0, Mem_Ack = 1'b0;
    logic [AW-1:0] Miss_Addr = '0;
    logic [DW-1:0] Mem_Data = '0;
    logic          Mem_Req, Fill_We, Fill_Bank, Bnd_We, Bnd_Bank, Active_Bank, Stall, Ready;
    logic [AW-1:0] Mem_Addr, Bnd_Lb;
    logic [2:0]    Fill_Idx;
    logic [DW-1:0] Fill_Data;

    icache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .Reset_n(Reset_n), .Switch(Switch), .Miss(Miss), .Miss_Addr(Miss_Addr),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data),
        .Fill_We(Fill_We), .Fill_Bank(Fill_Bank), .Fill_Idx(Fill_Idx), .Fill_Data(Fill_Data),
        .Bnd_We(Bnd_We), .Bnd_Bank(Bnd_Bank), .Bnd_Lb(Bnd_Lb),
        .Active_Bank(Active_Bank), .Stall(Stall), .Ready(Ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          req, stall, ready, act, fwe, bwe, idle;
        logic [AW-1:0] addr;
    } stat_t;
    typedef struct packed { logic bank; logic [2:0] idx; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic bank; logic [AW-1:0] lb; } bnd_t;

    stat_t sq[$];
    wr_t   wq[$];
    bnd_t  bq[$];

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 = demand fill, 1 = backup fill, 2 = both banks valid
    bit            m_started = 0;
    int            m_phase = 0;
    logic          m_act = 0;
    logic [AW-1:0] m_base = '0;
    int            m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit sw, input bit mi, input logic [AW-1:0] ma, input bit ak);
        stat_t e;
        logic  tb;
        bit    wr;
        int    p0;
        e = '0;
        if (!Reset_n || !m_started) begin
            e.stall = 1'b1;
            e.idle  = 1'b1;
            if (Reset_n) begin
                m_started = 1; m_phase = 0; m_act = 0; m_base = '0; m_cnt = 0;
            end else begin
                m_started = 0;
            end
            sq.push_back(e);
            return;
        end
        p0      = m_phase;
        tb      = (m_phase == 1) ? ~m_act : m_act;
        e.req   = (m_phase != 2);
        e.addr  = m_base + AW'(m_cnt);
        e.stall = (m_phase == 0);
        e.ready = (m_phase == 2);
        e.act   = m_act;
        wr      = e.req && ak && !mi;
        e.fwe   = wr;
        e.bwe   = wr && (m_cnt == 7);
        if (wr) wq.push_back('{bank: tb, idx: 3'(m_cnt), data: Mem_Data});
        if (e.bwe) bq.push_back('{bank: tb, lb: m_base});
        sq.push_back(e);
        if (mi) begin
            m_phase = 0; m_base = {ma[AW-1:3], 3'b000}; m_cnt = 0;
        end else begin
            if (wr) begin
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    if (m_phase == 0) begin m_phase = 1; m_base = m_base + AW'(8); end
                    else m_phase = 2;
                end
            end
            if (sw && p0 != 0) begin
                if (m_phase == 2) begin
                    m_act = ~m_act; m_base = m_base + AW'(8); m_cnt = 0; m_phase = 1;
                end else if (m_phase == 1) begin
                    m_act = ~m_act; m_phase = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit sw, input bit mi, input logic [AW-1:0] ma, input bit ak);
        @(negedge clk);
        Reset_n   = ~rst;
        Switch    = sw;
        Miss      = mi;
        Miss_Addr = ma;
        Mem_Ack   = ak;
        Mem_Data  = $urandom;
        model_step(sw, mi, ma, ak);
    endtask

    task automatic run_to_ready(input string name);
        int n = 0;
        while (m_phase != 2 && n < 100) begin cyc(0, 0, 0, '0, 1); n++; end
        chk({name, "_reach_ready"}, 64'(m_phase == 2), 64'd1);
    endtask

    initial begin : monitor
        stat_t e;
        wr_t   w;
        bnd_t  b;
        forever begin
            @(negedge clk);
            #2;
            if (sq.size() != 0) begin
                e = sq.pop_front();
                chk("mem_req", 64'(Mem_Req), 64'(e.req));
                chk("stall", 64'(Stall), 64'(e.stall));
                chk("ready", 64'(Ready), 64'(e.ready));
                chk("active_bank", 64'(Active_Bank), 64'(e.act));
                chk("fill_we", 64'(Fill_We), 64'(e.fwe));
                chk("bnd_we", 64'(Bnd_We), 64'(e.bwe));
                if (e.req || e.idle) chk("mem_addr", 64'(Mem_Addr), 64'(e.addr));
                if (e.idle) begin
                    chk("rst_fill_idx", 64'(Fill_Idx), 64'd0);
                    chk("rst_fill_bank", 64'(Fill_Bank), 64'd0);
                    chk("rst_bnd_bank", 64'(Bnd_Bank), 64'd0);
                    chk("rst_bnd_lb", 64'(Bnd_Lb), 64'd0);
                    chk("rst_fill_data", 64'(Fill_Data), 64'd0);
                end
                if (Fill_We || e.fwe) begin
                    if (wq.size() == 0) chk("write_expected", 64'd0, 64'd1);
                    else begin
                        w = wq.pop_front();
                        if (Fill_We) begin
                            chk("fill_bank", 64'(Fill_Bank), 64'(w.bank));
                            chk("fill_idx", 64'(Fill_Idx), 64'(w.idx));
                            chk("fill_data", 64'(Fill_Data), 64'(w.data));
                        end
                    end
                end
                if (Bnd_We || e.bwe) begin
                    if (bq.size() == 0) chk("bound_expected", 64'd0, 64'd1);
                    else begin
                        b = bq.pop_front();
                        if (Bnd_We) begin
                            chk("bnd_bank", 64'(Bnd_Bank), 64'(b.bank));
                            chk("bnd_lb", 64'(Bnd_Lb), 64'(b.lb));
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        bit legal, sw, mi;
        repeat (3) cyc(1, 0, 0, '0, 0);
        // Cold start: line 0 into bank 0, line 8 into bank 1
        cyc(0, 0, 0, '0, 1);
        run_to_ready("cold");
        // Switch from READY: prefetch 16..23 into old active bank 0
        cyc(0, 1, 0, '0, 1);
        run_to_ready("switch_ready");
        // Switch after 3 backup words: remaining words into the now-active bank
        cyc(0, 0, 1, 10'h000, 1);
        n = 0;
        while (!(m_phase == 1 && m_cnt == 3) && n < 100) begin cyc(0, 0, 0, '0, 1); n++; end
        cyc(0, 1, 0, '0, 1);
        run_to_ready("switch_bkp");
        // Miss mid-backup fill
        n = 0;
        cyc(0, 1, 0, '0, 1);
        while (!(m_phase == 1 && m_cnt == 4) && n < 100) begin cyc(0, 0, 0, '0, 1); n++; end
        cyc(0, 0, 1, 10'h2A5, 1);
        run_to_ready("miss_2a5");
        // Wrap at top of address space
        cyc(0, 0, 1, 10'h3FC, 1);
        run_to_ready("miss_3fc");
        // Toggling ack, reset dropped at word 5 of the demand fill
        cyc(1, 0, 0, '0, 0);
        cyc(0, 0, 0, '0, 0);
        n = 0;
        while (!(m_phase == 0 && m_cnt == 5) && n < 100) begin cyc(0, 0, 0, '0, n[0]); n++; end
        cyc(1, 0, 0, '0, 1);
        cyc(1, 0, 0, '0, 1);
        cyc(0, 0, 0, '0, 1);
        run_to_ready("reset_restart");
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            legal = m_started && m_phase != 0;
            sw = legal && ($urandom_range(0, 99) < 6);
            mi = ($urandom_range(0, 99) < 3);
            cyc(($urandom_range(0, 999) < 2), sw, mi, AW'($urandom), ($urandom_range(0, 99) < 70));
        end
        cyc(0, 0, 0, '0, 0);
        repeat (3) @(negedge clk);
        chk("status_q_drained", 64'(sq.size()), 64'd0);
        chk("write_q_drained", 64'(wq.size()), 64'd0);
        chk("bound_q_drained", 64'(bq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
